// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding,
// default FIFO depth and a depth-legality helper.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_t;

    localparam int DEFAULT_FIFO_DEPTH = 8;
    localparam int LEVEL_W            = 5;

    function automatic bit fifo_depth_ok(input int depth);
        return (depth >= 2) && (depth <= 16) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmit scheduler; head byte is visible
// combinationally on rdata, pushes when full and pops when empty are ignored.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LEVEL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap explicitly so the wrap point is obvious at the last slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin byte scheduler for two requesters in front of a UART transmitter.
// Define UART_TX_FIFO_EN to buffer bytes in uart_tx_fifo; otherwise bytes go straight to the UART.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic [7:0]         req0_data,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [7:0]         req1_data,
    output logic               req1_ready,
    input  logic               uart_busy,
    output logic               uart_wr,
    output logic [7:0]         uart_dat,
    output logic [LEVEL_W-1:0] fifo_level,
    output logic               idle
);

    if (!fifo_depth_ok(FIFO_DEPTH)) begin : g_bad_depth
        $error("uart_tx_sched: FIFO_DEPTH must be a power of two in 2..16");
    end

    tx_state_t  state;
    tx_state_t  state_next;
    logic       in_idle;
    logic       prio;
    logic       grant1;
    logic       any_valid;
    logic       accept;
    logic       start;
    logic [7:0] grant_data;
    logic [7:0] issue_data;

    // Port 1 wins when it is the only requester or when it holds priority.
    assign any_valid  = req0_valid | req1_valid;
    assign grant1     = req1_valid & (~req0_valid | prio);
    assign grant_data = grant1 ? req1_data : req0_data;

`ifdef UART_TX_FIFO_EN
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_head;

    assign accept     = reset & any_valid & ~fifo_full;
    assign start      = in_idle & ~fifo_empty & ~uart_busy;
    assign issue_data = fifo_head;
    assign idle       = in_idle & fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (start),
        .wdata (grant_data),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );
`else
    assign accept     = reset & any_valid & in_idle & ~uart_busy;
    assign start      = accept;
    assign issue_data = grant_data;
    assign idle       = in_idle;
    assign fifo_level = '0;
`endif

    assign req0_ready = accept & ~grant1;
    assign req1_ready = accept & grant1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:      if (start)      state_next = ST_ISSUE;
            ST_ISSUE:                     state_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (uart_busy)  state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!uart_busy) state_next = ST_IDLE;
            default:                      state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        uart_wr = (state == ST_ISSUE);
        in_idle = (state == ST_IDLE);
    end

    // The byte is captured on the IDLE->ISSUE edge and held until the next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uart_dat <= '0;
            prio     <= 1'b0;
        end else begin
            if (start) begin
                uart_dat <= issue_data;
            end
            if (accept) begin
                prio <= ~grant1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched against a queue-based reference model;
// covers both builds (with and without UART_TX_FIFO_EN).
module tb_uart_tx_sched;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req1_ready;
    logic       uart_busy = 1'b0;
    logic       uart_wr;
    logic [7:0] uart_dat;
    logic [4:0] fifo_level;
    logic       idle;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .uart_busy  (uart_busy),
        .uart_wr    (uart_wr),
        .uart_dat   (uart_dat),
        .fifo_level (fifo_level),
        .idle       (idle)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queued bytes plus transmitter progress flags.
    byte unsigned mq[$];
    bit           m_strobe;
    bit           m_inflight;
    bit           m_seen;
    bit           m_prio;
    bit           m_acc0;
    bit           m_acc1;
    logic [7:0]   m_dat;

    // UART emulation: busy for a few cycles starting one cycle after each strobe.
    bit           busy_hold;
    bit           busy_from_tx;
    int           busy_cnt;
    int           busy_len_max = 3;

    logic [7:0]   wr_log[$];
    logic [7:0]   exp_order [4];

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v0, input logic [7:0] d0,
                                  input logic v1, input logic [7:0] d1);
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_strobe     = 1'b0;
        m_inflight   = 1'b0;
        m_seen       = 1'b0;
        m_prio       = 1'b0;
        m_acc0       = 1'b0;
        m_acc1       = 1'b0;
        m_dat        = 8'h00;
        busy_cnt     = 0;
        busy_hold    = 1'b0;
        busy_from_tx = 1'b0;
        uart_busy    = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_bit({tag, "_req0_ready"}, req0_ready, 1'b0);
        check_bit({tag, "_req1_ready"}, req1_ready, 1'b0);
        check_bit({tag, "_uart_wr"}, uart_wr, 1'b0);
        check_byte({tag, "_uart_dat"}, uart_dat, 8'h00);
        check_byte({tag, "_level"}, {3'b000, fifo_level}, 8'h00);
        check_bit({tag, "_idle"}, idle, 1'b1);
    endtask

    // Compare this cycle's outputs with the model, then advance the model one cycle.
    task automatic check_output();
        bit         any_v;
        bit         win1;
        bit         free;
        bit         acc;
        bit         pop;
        bit         strobe_now;
        logic [7:0] acc_byte;

        any_v    = req0_valid | req1_valid;
        win1     = req1_valid && (!req0_valid || m_prio);
        free     = !m_strobe && !m_inflight;
        acc_byte = win1 ? req1_data : req0_data;
`ifdef UART_TX_FIFO_EN
        acc = any_v && (mq.size() < DEPTH);
        pop = free && !uart_busy && (mq.size() > 0);
`else
        acc = any_v && free && !uart_busy;
        pop = 1'b0;
`endif
        check_bit("req0_ready", req0_ready, acc && !win1);
        check_bit("req1_ready", req1_ready, acc && win1);
        check_bit("uart_wr", uart_wr, m_strobe);
        check_byte("uart_dat", uart_dat, m_dat);
        check_byte("fifo_level", {3'b000, fifo_level}, 8'(mq.size()));
        check_bit("idle", idle, (mq.size() == 0) && free);
        if (uart_wr === 1'b1) wr_log.push_back(uart_dat);

        m_acc0     = acc && !win1;
        m_acc1     = acc && win1;
        strobe_now = m_strobe;
        m_strobe   = 1'b0;
        if (strobe_now) begin
            m_inflight = 1'b1;
            m_seen     = 1'b0;
        end else if (m_inflight) begin
            if (!m_seen) m_seen = uart_busy;
            else if (!uart_busy) m_inflight = 1'b0;
        end
        if (pop) begin
            m_dat    = mq.pop_front();
            m_strobe = 1'b1;
        end
`ifdef UART_TX_FIFO_EN
        if (acc) mq.push_back(acc_byte);
`else
        if (acc) begin
            m_dat    = acc_byte;
            m_strobe = 1'b1;
        end
`endif
        if (acc) m_prio = !win1;
        if (strobe_now) busy_cnt = int'($urandom_range(1, busy_len_max));
    endtask

    task automatic tick();
        @(negedge clk);
        check_output();
        @(posedge clk);
        #1;
        busy_from_tx = (busy_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;
        uart_busy = busy_from_tx | busy_hold;
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b0;
        #1;
        check_reset_values(tag);
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n;
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
        busy_hold = 1'b0;
        n = 0;
        while ((mq.size() != 0 || m_strobe || m_inflight) && n < 200) begin
            tick();
            n++;
        end
        check_bit({tag, "_drained"}, n < 200, 1'b1);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        exp_order = '{8'hAA, 8'h55, 8'hAA, 8'h55};
        model_reset();
        #2;
        check_reset_values("por");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single byte from req0 produces exactly one strobe carrying it.
        wr_log.delete();
        apply_stimulus(1'b1, 8'h41, 1'b0, 8'h00);
        tick();
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) tick();
        check_byte("single_count", 8'(wr_log.size()), 8'd1);
        if (wr_log.size() > 0) check_byte("single_byte", wr_log[0], 8'h41);

        // Both ports continuously valid alternate starting with req0.
        apply_reset("rst_a");
        wr_log.delete();
        apply_stimulus(1'b1, 8'hAA, 1'b1, 8'h55);
        for (int i = 0; i < 100 && wr_log.size() < 4; i++) tick();
        check_bit("arb_four_strobes", wr_log.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < wr_log.size(); i++)
            check_byte($sformatf("arb_order%0d", i), wr_log[i], exp_order[i]);
        apply_reset("rst_b");

`ifdef UART_TX_FIFO_EN
        // Busy held: FIFO fills to its depth and refuses the ninth byte.
        busy_hold = 1'b1;
        uart_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(1'b1, 8'(8'h10 + i), 1'b0, 8'h00);
            tick();
        end
        check_byte("full_level", {3'b000, fifo_level}, 8'd8);
        check_bit("full_ready", req0_ready, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
        busy_hold = 1'b0;
        uart_busy = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_bit("level_drops", fifo_level < 5'd8, 1'b1);
        drain("full");
        apply_reset("rst_c");

        // Push and pop in the same cycle at level 3.
        busy_hold = 1'b1;
        uart_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 8'(8'hC0 + i), 1'b0, 8'h00);
            tick();
        end
        apply_stimulus(1'b1, 8'hD4, 1'b0, 8'h00);
        busy_hold = 1'b0;
        uart_busy = 1'b0;
        tick();
        check_byte("pushpop_level", {3'b000, fifo_level}, 8'd3);
        drain("pushpop");
        apply_reset("rst_d");
`else
        // Without a FIFO nothing is granted while the UART is busy.
        busy_hold = 1'b1;
        uart_busy = 1'b1;
        wr_log.delete();
        apply_stimulus(1'b1, 8'h11, 1'b1, 8'h22);
        for (int i = 0; i < 3; i++) tick();
        check_bit("nofifo_ready0_busy", req0_ready, 1'b0);
        check_bit("nofifo_ready1_busy", req1_ready, 1'b0);
        busy_hold = 1'b0;
        uart_busy = 1'b0;
        tick();
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) tick();
        check_byte("nofifo_count", 8'(wr_log.size()), 8'd1);
        if (wr_log.size() > 0) check_byte("nofifo_byte", wr_log[0], 8'h11);
        apply_reset("rst_d");
`endif

        // Reset while waiting for the UART discards everything buffered.
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b1, 8'(8'hE0 + i), 1'b0, 8'h00);
            tick();
            if (i == 2) busy_hold = 1'b1;
        end
        #2;
`ifdef UART_TX_FIFO_EN
        check_byte("pre_rst_level", {3'b000, fifo_level}, 8'd5);
`endif
        apply_reset("rst_mid");
        wr_log.delete();
        for (int i = 0; i < 5; i++) tick();
        check_byte("post_rst_strobes", 8'(wr_log.size()), 8'd0);
        apply_stimulus(1'b1, 8'h77, 1'b0, 8'h00);
        tick();
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) tick();
        check_byte("post_rst_count", 8'(wr_log.size()), 8'd1);
        drain("post_rst");

        // Randomized traffic with requesters holding data until accepted.
        apply_reset("rst_rand");
        busy_len_max = 4;
        for (int i = 0; i < 600; i++) begin
            if (!req0_valid || m_acc0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_data  = 8'($urandom);
            end
            if (!req1_valid || m_acc1) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_data  = 8'($urandom);
            end
            if ($urandom_range(0, 19) == 0) begin
                busy_hold = !busy_hold;
                uart_busy = busy_from_tx | busy_hold;
            end
            tick();
        end
        drain("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  system clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req0_valid  input  1  CPU store port has a byte.
REQ-005 SHALL have port req0_data  input  8  CPU byte.
REQ-006 SHALL have port req0_ready  output  1  CPU byte accepted this cycle when valid&ready.
REQ-007 SHALL have ports req1_valid/req1_data/req1_ready, with the same widths and meaning, for the debug/trace port.
REQ-008 SHALL have port uart_busy  input  1  busy flag from the uart instance (bitcount[3:1] nonzero).
REQ-009 SHALL have port uart_wr  output  1  one-cycle transmit strobe to the uart.
REQ-010 SHALL have port uart_dat  output  8  byte presented with uart_wr.
REQ-011 SHALL have port fifo_level  output  5  current FIFO occupancy.
REQ-012 SHALL have port idle  output  1  FIFO empty and FSM in IDLE.

Function
REQ-013 SHALL arbitrate round-robin between req0 and req1: priority pointer starts at 0 and moves to the other port after each accepted byte; a lone valid requester always wins.
REQ-014 SHALL accept at most one byte per cycle, asserting ready only to the granted requester, and only when the FIFO is not full at cycle start (no bypass on simultaneous pop).
REQ-015 SHALL push the accepted byte into the FIFO in the same edge; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-016 SHALL run FSM IDLE->ISSUE->WAIT_BUSY->WAIT_DONE->IDLE.
REQ-017 IDLE: if FIFO nonempty and uart_busy=0, pop head and go to ISSUE.
REQ-018 ISSUE: uart_wr=1 for exactly one cycle with uart_dat=popped byte; next state WAIT_BUSY.
REQ-019 WAIT_BUSY: hold until uart_busy=1 (it rises one cycle after the strobe), then WAIT_DONE; uart_wr SHALL never be asserted here.
REQ-020 WAIT_DONE: hold until uart_busy=0, then IDLE; minimum strobe-to-strobe spacing is 4 cycles.
REQ-021 uart_dat SHALL hold its last value outside ISSUE.
REQ-022 Simultaneous push and pop SHALL leave fifo_level unchanged; level SHALL never exceed FIFO_DEPTH or underflow.

Reset
REQ-023 On reset low (asynchronous): FSM=IDLE, FIFO pointers and fifo_level=0, priority pointer=0, uart_wr=0, uart_dat=0, req0_ready=req1_ready=0, idle=1.
REQ-024 Reset mid-transfer SHALL discard FIFO contents and any in-flight byte; no strobe for 1 cycle after deassertion.

Configuration
REQ-025 With UART_TX_FIFO_EN defined, the FIFO of REQ-014/015 SHALL be present.
REQ-026 Without UART_TX_FIFO_EN, no FIFO: the granted requester's ready SHALL assert only in IDLE with uart_busy=0, the byte going directly to ISSUE; fifo_level tied 0.

Structure
REQ-027 FSM state encoding and the default FIFO depth SHALL live in shared package uart_pkg.
REQ-028 The FIFO SHALL be a sub-module uart_tx_fifo (push, pop, data, full, empty, level).

Verification
REQ-029 req0 sends 0x41 alone -> req0_ready 1 cycle, uart_wr pulse with uart_dat=0x41 at cycle 2, single strobe only.
REQ-030 req0 and req1 both valid continuously with 0xAA/0x55 -> accepted order AA,55,AA,55; uart strobes in same order.
REQ-031 uart_busy held 1, push 9 bytes (depth 8) -> 8 accepted, ninth ready=0, fifo_level=8; release busy -> level drops.
REQ-032 Push while popping at level 3 -> level stays 3 that cycle.
REQ-033 Reset asserted in WAIT_DONE with level 5 -> level=0, idle=1, no uart_wr until new push.
REQ-034 Build without UART_TX_FIFO_EN, uart_busy=1 -> both readys 0; busy falls -> one byte granted and strobed.
